w_adder_arbiter: RTL
====================

// Module: w_adder_arbiter
// PURPOSE
//   Shares one signed N-bit adder (W_Adder #(N), (N+2)-bit SUM) between R requesters.
//   Round-robin arbitration, valid/ready on both sides, one registered result slot.
//   Sits between client datapaths and the shared adder; tags each result with the winning ID.
// PARAMETERS
//   N   8  operand width (signed)
//   R   4  number of requesters, 2..16; IDW = $clog2(R)
// PORTS
//   CLK        in   1        clock, all state on rising edge
//   RST_N      in   1        asynchronous active-low reset
//   REQ_VALID  in   R        per-requester operand valid
//   REQ_A      in   R*N      packed signed operands A, slice i = [i*N +: N]
//   REQ_B      in   R*N      packed signed operands B, same packing
//   REQ_READY  out  R        one-hot grant; transfer on REQ_VALID[i] & REQ_READY[i]
//   RSP_VALID  out  1        result slot full
//   RSP_READY  in   1        downstream accepts result
//   RSP_SUM    out  N+2      signed A+B of granted requester, sign-extended
//   RSP_ID     out  IDW      index of requester that produced RSP_SUM
// BEHAVIOUR
//   Reset (async, RST_N=0): RSP_VALID=0, RSP_SUM=0, RSP_ID=0, rr pointer=0, state EMPTY.
//     REQ_READY=0 while RST_N=0. Reset mid-transaction drops the held result silently.
//   FSM (state = result slot): EMPTY, FULL.
//     can_accept = (state==EMPTY) | (RSP_VALID & RSP_READY).
//     EMPTY: any REQ_VALID -> grant, load slot -> FULL; none -> stay EMPTY.
//     FULL: RSP_READY=0 -> hold RSP_SUM/RSP_ID stable, REQ_READY=0.
//           RSP_READY=1 & new request -> drain and reload same cycle, stay FULL.
//           RSP_READY=1 & no request -> EMPTY.
//   Arbitration: round-robin from pointer P; winner = first i in P, P+1, .. (mod R)
//     with REQ_VALID[i]. REQ_READY = onehot(winner) & can_accept, else 0.
//     On grant, P <= winner+1 (wraps R-1 -> 0). No grant -> P unchanged.
//   REQ_READY combinational from REQ_VALID, RSP_READY, state; REQ_READY never
//     depends on REQ_A/REQ_B.
//   Latency: accept in cycle t -> RSP_VALID=1 with result in t+1. Throughput 1/cycle
//     when RSP_READY held high.
//   Arithmetic: both operands sign-extended to N+2 before add; no overflow possible.
//     Max 127+127=254 (N=8), min -128+-128=-256.
//   Requester i may drop REQ_VALID without transfer; no state is kept for it.
// CONFIGURATION
//   W_ADDER_ARB_SUB_EN defined: extra port REQ_SUB in R (bit i per requester);
//     granted REQ_SUB=1 -> RSP_SUM = A - B (ext. to N+2), else A + B.
//     Result range -128-127=-255 .. 127+128=255 fits N+2.
//   Not defined: no REQ_SUB port, always A + B.
// STRUCTURE
//   Package w_adder_arb_pkg: typedef enum {EMPTY, FULL} slot_state_t;
//     function idw(R) returning $clog2(R) (min 1).
//   Sub-module w_rr_arbiter #(R): REQ vector + pointer in, one-hot grant + winner
//     index out, purely combinational; pointer register stays in top.
//   Top: operand mux by winner, one W_Adder #(N) instance (or subtract path under
//     macro), result/ID/valid registers, FSM.
// TESTING
//   1 Reset: RST_N=0 mid-FULL -> RSP_VALID=0, REQ_READY=0 immediately, P=0 after release.
//   2 Single req: R=4, REQ_VALID=0010, A1=100, B1=27, RSP_READY=1 -> next cycle
//     RSP_VALID=1, RSP_SUM=127, RSP_ID=1.
//   3 Fairness: REQ_VALID=1111 held, RSP_READY=1 -> RSP_ID sequence 0,1,2,3,0 on
//     consecutive cycles.
//   4 Backpressure: slot FULL (SUM=-256 from A=B=-128), RSP_READY=0 for 3 cycles
//     -> SUM/ID stable, REQ_READY=0000; RSP_READY=1 -> drain + new grant same cycle.
//   5 Wrap: P=3, REQ_VALID=1001 -> grant 3 then 0; P=3, REQ_VALID=0001 -> grant 0, P=1.
//   6 W_ADDER_ARB_SUB_EN: A=-128, B=127, REQ_SUB=1 -> RSP_SUM=-255; REQ_SUB=0 -> -1.

Source files
------------

// File: rtl/w_adder_arb_pkg.sv
// Shared types and helpers for the shared-adder arbiter.
package w_adder_arb_pkg;

  // Result slot occupancy: the slot is the only storage in the block.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_t;

  // Requester index width; a single requester still needs one bit.
  function automatic int idw(input int r);
    return (r <= 2) ? 1 : $clog2(r);
  endfunction

endpackage

// File: rtl/W_Adder.sv
// Signed N-bit adder producing an (N+2)-bit sign-extended sum (cannot overflow).
module W_Adder #(
  parameter int N = 8
) (
  input  logic signed [N-1:0] A,
  input  logic signed [N-1:0] B,
  output logic signed [N+1:0] SUM
);

  assign SUM = {{2{A[N-1]}}, A} + {{2{B[N-1]}}, B};

endmodule

// File: rtl/w_rr_arbiter.sv
// Combinational round-robin picker: first valid requester at or after ptr.
// The pointer register lives in the parent so grant/advance stay in one place.
module w_rr_arbiter
  import w_adder_arb_pkg::*;
#(
  parameter  int R   = 4,
  localparam int IDW = idw(R)
) (
  input  logic [R-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [R-1:0]   gnt,
  output logic [IDW-1:0] win,
  output logic           any
);

  // Scan R slots starting at ptr, wrapping modulo R; first hit wins.
  always_comb begin
    int             idx;
    logic [IDW-1:0] idx_w;
    idx   = 0;
    idx_w = '0;
    gnt   = '0;
    win   = '0;
    any   = 1'b0;
    for (int k = 0; k < R; k++) begin
      idx = int'(ptr) + k;
      if (idx >= R) idx = idx - R;
      idx_w = IDW'(idx);
      if (!any && req[idx_w]) begin
        any = 1'b1;
        win = idx_w;
      end
    end
    if (any) gnt[win] = 1'b1;
  end

endmodule

// File: rtl/w_adder_arbiter.sv
// Shares one signed adder between R requesters with round-robin arbitration
// and a single registered result slot tagged with the winning requester ID.
// Optional: define W_ADDER_ARB_SUB_EN to add per-requester REQ_SUB (A - B).
module w_adder_arbiter
  import w_adder_arb_pkg::*;
#(
  parameter  int N   = 8,
  parameter  int R   = 4,
  localparam int IDW = idw(R)
) (
  input  logic           CLK,
  input  logic           RST_N,
  input  logic [R-1:0]   REQ_VALID,
  input  logic [R*N-1:0] REQ_A,
  input  logic [R*N-1:0] REQ_B,
`ifdef W_ADDER_ARB_SUB_EN
  input  logic [R-1:0]   REQ_SUB,
`endif
  output logic [R-1:0]   REQ_READY,
  output logic           RSP_VALID,
  input  logic           RSP_READY,
  output logic [N+1:0]   RSP_SUM,
  output logic [IDW-1:0] RSP_ID
);

  slot_state_t    state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [N+1:0]   sum_q, sum_d;
  logic [IDW-1:0] id_q, id_d;

  logic [R-1:0]      gnt;
  logic [IDW-1:0]    win;
  logic              any_vld;
  logic              can_accept;
  logic              fire;
  logic signed [N-1:0] a_sel, b_sel;
  logic signed [N+1:0] add_sum, res;

  w_rr_arbiter #(.R(R)) u_arb (
    .req (REQ_VALID),
    .ptr (ptr_q),
    .gnt (gnt),
    .win (win),
    .any (any_vld)
  );

  // Operands of the winner only; grant never looks at operand values.
  assign a_sel = REQ_A[win*N +: N];
  assign b_sel = REQ_B[win*N +: N];

  W_Adder #(.N(N)) u_add (
    .A   (a_sel),
    .B   (b_sel),
    .SUM (add_sum)
  );

`ifdef W_ADDER_ARB_SUB_EN
  // Subtract on the extended operands so -(-2^(N-1)) is representable.
  always_comb begin
    res = add_sum;
    if (REQ_SUB[win])
      res = $signed({{2{a_sel[N-1]}}, a_sel}) - $signed({{2{b_sel[N-1]}}, b_sel});
  end
`else
  assign res = add_sum;
`endif

  // Slot can take a new result when empty or when it drains this cycle.
  assign can_accept = (state_q == EMPTY) | ((state_q == FULL) & RSP_READY);
  assign fire       = can_accept & any_vld;
  assign REQ_READY  = gnt & {R{can_accept & RST_N}};

  assign RSP_VALID  = (state_q == FULL);
  assign RSP_SUM    = sum_q;
  assign RSP_ID     = id_q;

  // Slot FSM, result capture and round-robin pointer advance.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sum_d   = sum_q;
    id_d    = id_q;
    if (fire) begin
      state_d = FULL;
      sum_d   = res;
      id_d    = win;
      ptr_d   = (win == IDW'(R-1)) ? '0 : win + 1'b1;
    end else if ((state_q == FULL) && RSP_READY) begin
      state_d = EMPTY;
    end
  end

  // State registers; reset drops any held result.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= EMPTY;
      ptr_q   <= '0;
      sum_q   <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sum_q   <= sum_d;
      id_q    <= id_d;
    end
  end

endmodule
